// File: rtl/comp_seq_nbit.sv
// comp_seq_nbit
//   Sequential magnitude comparator. Compares two WIDTH-bit operands one
//   CHUNK-bit slice per clock, most significant slice first, and finishes at
//   the first slice that differs (or after slice 0 when the operands are equal).
//   Supports unsigned and two's-complement compares, with a start/done handshake.
//
// Parameters
//   WIDTH  operand width, integer multiple of CHUNK
//   CHUNK  slice width examined per cycle
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        compare request, accepted only while idle
//   a, b         operands, captured on the accepting edge
//   signed_mode  1 = two's-complement compare, 0 = unsigned; captured with a/b
//   busy         high while a compare is in progress
//   done         one-cycle pulse when e/l/g update
//   e, l, g      result flags A==B, A<B, A>B; held until the next completion
module comp_seq_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             l,
  output logic             g
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NCHUNK - 1);
  // Flipping the sign bit of both operands turns a two's-complement compare
  // into an unsigned (offset-binary) compare of the top slice.
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  b_reg, b_next;
  logic              signed_reg, signed_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              done_reg, done_next;
  logic              e_reg, e_next;
  logic              l_reg, l_next;
  logic              g_reg, g_next;

  // Slice views of the captured operands
  logic [CHUNK-1:0]  a_slice [NCHUNK];
  logic [CHUNK-1:0]  b_slice [NCHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : gen_slice
      assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  logic             flip_msb;
  logic [CHUNK-1:0] cur_a, cur_b;
  logic             slice_lt, slice_gt, slice_eq, last_slice, finish;

  always_comb begin
    flip_msb   = signed_reg && (idx_reg == TOP_IDX);
    cur_a      = a_slice[idx_reg] ^ (flip_msb ? MSB_MASK : '0);
    cur_b      = b_slice[idx_reg] ^ (flip_msb ? MSB_MASK : '0);
    slice_lt   = (cur_a < cur_b);
    slice_gt   = (cur_a > cur_b);
    slice_eq   = (cur_a == cur_b);
    last_slice = (idx_reg == '0);
    finish     = (state_reg == COMPARE) && (!slice_eq || last_slice);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      idx_reg    <= '0;
      done_reg   <= 1'b0;
      e_reg      <= 1'b0;
      l_reg      <= 1'b0;
      g_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      idx_reg    <= idx_next;
      done_reg   <= done_next;
      e_reg      <= e_next;
      l_reg      <= l_next;
      g_reg      <= g_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    idx_next    = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next      = a;
          b_next      = b;
          signed_next = signed_mode;
          idx_next    = TOP_IDX;
          state_next  = COMPARE;
        end
      end
      COMPARE: begin
        if (finish) begin
          state_next = IDLE;
        end else begin
          idx_next = idx_reg - IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result logic: flags only change on completion, so the previous result
  // stays visible while a new compare runs.
  always_comb begin
    done_next = 1'b0;
    e_next    = e_reg;
    l_next    = l_reg;
    g_next    = g_reg;
    if (finish) begin
      done_next = 1'b1;
      e_next    = slice_eq;
      l_next    = slice_lt;
      g_next    = slice_gt;
    end
  end

  assign busy = (state_reg == COMPARE);
  assign done = done_reg;
  assign e    = e_reg;
  assign l    = l_reg;
  assign g    = g_reg;

endmodule

// File: tb/tb_comp_seq_nbit.sv
module tb_comp_seq_nbit;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             busy, done, e, l, g;

  int   total = 0;
  int   bad   = 0;
  // Result expected to be held on e/l/g (last completed compare)
  logic pe = 1'b0, pl = 1'b0, pg = 1'b0;

  always #5 clk = ~clk;

  comp_seq_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .e(e), .l(l), .g(g)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Slices examined = slices from the top down to the highest differing one.
  function automatic int exp_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    int hi;
    d  = x ^ y;
    hi = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) hi = i;
    if (hi < 0) return NCHUNK;
    return NCHUNK - hi / CHUNK;
  endfunction

  // Starts a compare in the current cycle and returns in the done cycle.
  task automatic do_compare(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                            input logic sm, input string name);
    int   k, c;
    logic xe, xl, xg;
    k  = exp_latency(xa, xb);
    xe = (xa == xb);
    if (sm) begin
      xl = ($signed(xa) < $signed(xb));
      xg = ($signed(xa) > $signed(xb));
    end else begin
      xl = (xa < xb);
      xg = (xa > xb);
    end
    a = xa; b = xb; signed_mode = sm; start = 1'b1;
    tick;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom);
    c = 0;
    forever begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || {e, l, g} !== {pe, pl, pg}) begin
        bad++;
        $display("FAIL %s busy_hold: cyc=%0d busy=%b done=%b elg=%b%b%b required busy=1 done=0 elg=%b%b%b",
                 name, c, busy, done, e, l, g, pe, pl, pg);
      end
      tick;
      c++;
      if (done === 1'b1) break;
      if (c >= NCHUNK + 2) begin
        total++; bad++;
        $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, c, k);
        return;
      end
    end
    total++;
    if (c != k || busy !== 1'b0 || {e, l, g} !== {xe, xl, xg}) begin
      bad++;
      $display("FAIL %s result: a=%h b=%h sm=%b lat=%0d busy=%b elg=%b%b%b required lat=%0d busy=0 elg=%b%b%b",
               name, xa, xb, sm, c, busy, e, l, g, k, xe, xl, xg);
    end else begin
      $display("ok %s: a=%h b=%h sm=%b lat=%0d elg=%b%b%b", name, xa, xb, sm, c, e, l, g);
    end
    pe = xe; pl = xl; pg = xg;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    total++;
    if ({busy, done, e, l, g} !== 5'b0) begin
      bad++;
      $display("FAIL reset: busy/done/e/l/g=%b required 00000", {busy, done, e, l, g});
    end else $display("ok reset");
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    do_compare(8'h00, 8'h00, 1'b0, "eq_zero");   tick;
    do_compare(8'h40, 8'h80, 1'b0, "top_lt");    tick;
    do_compare(8'h80, 8'h01, 1'b1, "signed_lt"); tick;
    do_compare(8'h80, 8'h01, 1'b0, "unsig_gt");  tick;
    do_compare(8'h03, 8'h02, 1'b0, "low_gt");    tick;
    do_compare(8'hFF, 8'hFE, 1'b1, "sneg_gt");   tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_start_ignored;
    int c;
    a = 8'h00; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    tick;
    a = 8'h40; b = 8'h80; start = 1'b1;   // must be ignored
    tick;
    start = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < NCHUNK + 2) begin
      tick;
      c++;
    end
    total++;
    if (c != NCHUNK || {e, l, g} !== 3'b100) begin
      bad++;
      $display("FAIL start_ignored: lat=%0d elg=%b%b%b required lat=%0d elg=100", c, e, l, g, NCHUNK);
    end else $display("ok start_ignored: lat=%0d elg=%b%b%b", c, e, l, g);
    pe = 1'b1; pl = 1'b0; pg = 1'b0;
  endtask

  task automatic test_back_to_back;
    // Called in a done cycle: start here must be accepted.
    do_compare(8'h55, 8'h55, 1'b0, "b2b_eq");
    do_compare(8'h12, 8'hC0, 1'b1, "b2b_sgt");
    tick;
  endtask

  task automatic test_reset_abort;
    a = 8'h00; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    total++;
    if ({busy, done, e, l, g} !== 5'b0) begin
      bad++;
      $display("FAIL abort_state: busy/done/e/l/g=%b required 00000", {busy, done, e, l, g});
    end else $display("ok abort_state");
    pe = 1'b0; pl = 1'b0; pg = 1'b0;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet: cyc=%0d done=%b busy=%b required 0 0", i, done, busy);
      end
      tick;
    end
    do_compare(8'h9A, 8'h9B, 1'b0, "after_reset");
    tick;
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] x, y;
    logic             sm;
    for (int i = 0; i < 150; i++) begin
      x  = WIDTH'($urandom);
      sm = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: y = WIDTH'($urandom);
      endcase
      do_compare(x, y, sm, "rand");
      if ($urandom_range(0, 1) == 1) begin
        tick;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL rand_pulse: done=%b busy=%b required 0 0", done, busy);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_directed;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
